ram_bus_bridge: RTL and testbench



---
 rtl/ram_bus_bridge_pkg.sv | 31 +++
 rtl/ram_bus_timeout_counter.sv | 41 ++++
 rtl/ram_bus_bridge.sv | 154 +++++++++++++++
 tb/tb_ram_bus_bridge.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_bus_bridge_pkg.sv
//==============================================================================
// Module      : ram_bus_bridge_pkg
// Description : Shared encodings and widths for the RAM-to-bus bridge: FSM
//               state codes, RAM operation codes, byte-select width and the
//               core register-bus widths.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package ram_bus_bridge_pkg;

    // Bridge FSM state encodings
    localparam logic [1:0] c_st_idle    = 2'b00;
    localparam logic [1:0] c_st_request = 2'b01;
    localparam logic [1:0] c_st_done    = 2'b10;

    // Core RAM operation codes
    localparam logic c_ram_write = 1'b1;
    localparam logic c_ram_read  = 1'b0;

    // Byte-select bus width (one bit per byte lane)
    localparam int c_sel_width = 4;

    // Register-bus widths used by the core
    localparam int c_reg_addr_width = 32;
    localparam int c_reg_data_width = 32;

endpackage

`default_nettype wire

// File: rtl/ram_bus_timeout_counter.sv
//==============================================================================
// Module      : ram_bus_timeout_counter
// Description : Counts cycles spent waiting for a slave acknowledge. The
//               expired flag is raised on the last permitted wait cycle,
//               i.e. when the count reaches TIMEOUT_CYCLES-1.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_bus_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int                     c_cnt_width = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_width-1:0] c_last      = c_cnt_width'(TIMEOUT_CYCLES - 1);

    logic [c_cnt_width-1:0] r_count;

    // Wait-cycle counter: clear wins over increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expired = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/ram_bus_bridge.sv
//==============================================================================
// Module      : ram_bus_bridge
// Description : Converts the core's single-cycle RAM access into a registered
//               request/acknowledge transaction towards a variable-latency
//               slave, stalling the pipeline until the release cycle.
//               Optional feature macro: RAM_BUS_BRIDGE_WRITE_POST_EN
//               (writes are posted and do not stall the core).
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module ram_bus_bridge
    import ram_bus_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = c_reg_addr_width,
    parameter int DATA_WIDTH     = c_reg_data_width,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_chip_enable,
    input  logic                   cpu_operation,
    input  logic [c_sel_width-1:0] cpu_select_signal,
    input  logic [ADDR_WIDTH-1:0]  cpu_addr,
    input  logic [DATA_WIDTH-1:0]  cpu_write_data,
    output logic [DATA_WIDTH-1:0]  cpu_read_data,
    output logic                   stall_request,
    output logic                   bus_error,
    output logic                   mem_request,
    output logic                   mem_write_enable,
    output logic [c_sel_width-1:0] mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]  mem_write_data,
    input  logic [DATA_WIDTH-1:0]  mem_read_data,
    input  logic                   mem_ack
);

    logic [1:0]             r_state;
    logic                   r_mem_request;
    logic                   r_mem_write_enable;
    logic [c_sel_width-1:0] r_mem_byte_enable;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [DATA_WIDTH-1:0]  r_mem_write_data;
    logic [DATA_WIDTH-1:0]  r_read_data;
    logic                   r_bus_error;
    logic                   r_posted_txn;

    logic w_accept;
    logic w_cnt_enable;
    logic w_expired;
    logic w_stall;
    logic w_unused_addr_bits;

    // The slave is word-addressed; byte offset is carried by the byte enables
    assign w_unused_addr_bits = ^cpu_addr[1:0];

    assign w_accept     = (r_state == c_st_idle) && cpu_chip_enable;
    assign w_cnt_enable = (r_state == c_st_request) && !mem_ack && !w_expired;

    ram_bus_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk       (clock),
        .rst       (reset),
        .i_clear   (w_accept),
        .i_enable  (w_cnt_enable),
        .o_expired (w_expired)
    );

    // Transaction FSM with registered slave-side outputs and read capture
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state            <= c_st_idle;
            r_mem_request      <= 1'b0;
            r_mem_write_enable <= 1'b0;
            r_mem_byte_enable  <= '0;
            r_mem_addr         <= '0;
            r_mem_write_data   <= '0;
            r_read_data        <= '0;
            r_bus_error        <= 1'b0;
            r_posted_txn       <= 1'b0;
        end else begin
            r_bus_error <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cpu_chip_enable) begin
                        r_mem_request      <= 1'b1;
                        r_mem_write_enable <= cpu_operation;
                        r_mem_byte_enable  <= cpu_select_signal;
                        r_mem_addr         <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_write_data   <= cpu_write_data;
`ifdef RAM_BUS_BRIDGE_WRITE_POST_EN
                        r_posted_txn       <= (cpu_operation == c_ram_write);
`else
                        r_posted_txn       <= 1'b0;
`endif
                        r_state            <= c_st_request;
                    end
                end
                c_st_request: begin
                    if (mem_ack) begin
                        r_mem_request <= 1'b0;
                        r_read_data   <= (r_mem_write_enable == c_ram_read) ? mem_read_data : '0;
                        r_state       <= c_st_done;
                    end else if (w_expired) begin
                        r_mem_request <= 1'b0;
                        r_read_data   <= '0;
                        r_bus_error   <= 1'b1;
                        r_state       <= c_st_done;
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state       <= c_st_idle;
                    r_mem_request <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_BUS_BRIDGE_WRITE_POST_EN
    // Posted writes release the core at once; any access arriving while a
    // post is outstanding (including its release cycle) waits for its turn
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            c_st_idle:    w_stall = cpu_chip_enable && (cpu_operation != c_ram_write);
            c_st_request: w_stall = cpu_chip_enable;
            c_st_done:    w_stall = cpu_chip_enable && r_posted_txn;
            default:      w_stall = cpu_chip_enable;
        endcase
    end
`else
    // Freeze the core from acceptance until the release cycle
    always_comb begin
        w_stall = cpu_chip_enable && (r_state != c_st_done) && !r_posted_txn;
    end
`endif

    assign stall_request    = w_stall;
    assign cpu_read_data    = (r_state == c_st_done) ? r_read_data : '0;
    assign bus_error        = r_bus_error;
    assign mem_request      = r_mem_request;
    assign mem_write_enable = r_mem_write_enable;
    assign mem_byte_enable  = r_mem_byte_enable;
    assign mem_addr         = r_mem_addr;
    assign mem_write_data   = r_mem_write_data;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_bridge.sv
//==============================================================================
// Module      : tb_ram_bus_bridge
// Description : Self-checking bench for ram_bus_bridge (TIMEOUT_CYCLES=4).
//               Table of transactions applied back-to-back with a scoreboard
//               of expected release results, plus reset and posted-write
//               sequences. Posted sequence built with
//               RAM_BUS_BRIDGE_WRITE_POST_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ram_bus_bridge;
    import ram_bus_bridge_pkg::*;

    localparam int c_to = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpu_chip_enable;
    logic        cpu_operation;
    logic [3:0]  cpu_select_signal;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_write_data;
    logic [31:0] cpu_read_data;
    logic        stall_request;
    logic        bus_error;
    logic        mem_request;
    logic        mem_write_enable;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
    logic        mem_ack;

    ram_bus_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (32),
        .TIMEOUT_CYCLES (c_to)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .cpu_chip_enable   (cpu_chip_enable),
        .cpu_operation     (cpu_operation),
        .cpu_select_signal (cpu_select_signal),
        .cpu_addr          (cpu_addr),
        .cpu_write_data    (cpu_write_data),
        .cpu_read_data     (cpu_read_data),
        .stall_request     (stall_request),
        .bus_error         (bus_error),
        .mem_request       (mem_request),
        .mem_write_enable  (mem_write_enable),
        .mem_byte_enable   (mem_byte_enable),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .mem_read_data     (mem_read_data),
        .mem_ack           (mem_ack)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          waits;
        int          exp_stall;
        logic [31:0] exp_rd;
        int          exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rd;
        int          err;
        int          stall;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[7];
    int   checks = 0;
    int   errors = 0;
    int   req_rises = 0;
    logic req_prev = 1'b0;
    int   n_run;
    int   base_rises;

    // Counts request pulses issued to the slave
    always @(negedge clock) begin
        if (mem_request && !req_prev) req_rises++;
        req_prev = mem_request;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   seen;
        int   stalls;
        int   errs;
        int   cyc;
        bit   done;
        cpu_chip_enable   = 1'b1;
        cpu_operation     = v.we;
        cpu_select_signal = v.sel;
        cpu_addr          = v.addr;
        cpu_write_data    = v.wdata;
        e.rd = v.exp_rd; e.err = v.exp_err; e.stall = v.exp_stall;
        sb_q.push_back(e);
        seen = 0; stalls = 0; errs = 0; cyc = 0; done = 1'b0;
        while (!done) begin
            #1;
            if (mem_request) begin
                if (seen == 0) begin
                    check($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr & 32'hFFFF_FFFC);
                    check($sformatf("v%0d_mem_we", idx), mem_write_enable, v.we);
                    check($sformatf("v%0d_mem_be", idx), mem_byte_enable, v.sel);
                    check($sformatf("v%0d_mem_wdata", idx), mem_write_data, v.wdata);
                end
                mem_ack       = (seen == v.waits);
                mem_read_data = (seen == v.waits) ? v.rdata : 32'h0BAD_0BAD;
                seen++;
            end else begin
                mem_ack = 1'b0;
            end
            if (bus_error) errs++;
            if (!stall_request) begin
                done = 1'b1;
                if (sb_q.size() == 0) begin
                    check($sformatf("v%0d_sb_underflow", idx), 0, 1);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("v%0d_rdata", idx), cpu_read_data, e.rd);
                    check($sformatf("v%0d_stall_cycles", idx), stalls, e.stall);
                    check($sformatf("v%0d_bus_error_pulses", idx), errs, e.err);
                    check($sformatf("v%0d_req_cycles", idx), seen, (e.err != 0) ? c_to : v.waits + 1);
                end
            end else begin
                stalls++;
            end
            cyc++;
            if (!done && cyc > 40) begin
                check($sformatf("v%0d_release_timeout", idx), 0, 1);
                done = 1'b1;
            end
            @(negedge clock);
        end
        mem_ack = 1'b0;
    endtask

`ifdef RAM_BUS_BRIDGE_WRITE_POST_EN
    int p_seen, p_stalls, p_cyc;
    bit p_done;
    exp_t p_e;
`endif

    initial begin
        #200000;
        $display("FAIL global_watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_chip_enable = 1'b0; cpu_operation = 1'b0; cpu_select_signal = 4'h0;
        cpu_addr = '0; cpu_write_data = '0; mem_read_data = '0; mem_ack = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        check("rst_mem_request", mem_request, 0);
        check("rst_mem_we", mem_write_enable, 0);
        check("rst_mem_be", mem_byte_enable, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_cpu_rdata", cpu_read_data, 0);
        check("rst_bus_error", bus_error, 0);
        check("rst_stall", stall_request, 0);
        reset = 1'b0;
        @(negedge clock);

        //           we    sel     addr          wdata         rdata         waits stall exp_rd        err
        tbl[0] = '{1'b0, 4'hF, 32'h0000_0104, 32'h0000_0000, 32'hDEAD_BEEF, 0,  2, 32'hDEAD_BEEF, 0};
        tbl[1] = '{1'b1, 4'h3, 32'h0000_0200, 32'h1234_5678, 32'h5555_AAAA, 3,  5, 32'h0000_0000, 0};
        tbl[2] = '{1'b0, 4'hF, 32'h0000_0107, 32'h0000_0000, 32'hA5A5_5A5A, 1,  3, 32'hA5A5_5A5A, 0};
        tbl[3] = '{1'b0, 4'hF, 32'h0000_0400, 32'h0000_0000, 32'h7777_7777, 99, 5, 32'h0000_0000, 1};
        tbl[4] = '{1'b0, 4'hF, 32'h0000_0408, 32'h0000_0000, 32'h0F0F_1234, 0,  2, 32'h0F0F_1234, 0};
        tbl[5] = '{1'b1, 4'hC, 32'h0000_040C, 32'hCAFE_0001, 32'h9999_9999, 0,  2, 32'h0000_0000, 0};
        tbl[6] = '{1'b0, 4'hF, 32'h0000_0410, 32'h0000_0000, 32'h1357_9BDF, 2,  4, 32'h1357_9BDF, 0};

        base_rises = req_rises;
        n_run = 0;
        for (int i = 0; i < 7; i++) begin
`ifdef RAM_BUS_BRIDGE_WRITE_POST_EN
            if (tbl[i].we) continue;
`endif
            run_vec(tbl[i], i);
            n_run++;
        end
        cpu_chip_enable = 1'b0;
        #1;
        check("req_pulse_count", req_rises - base_rises, n_run);
        check("sb_drained", sb_q.size(), 0);

        // Reset asserted in the second REQUEST cycle
        @(negedge clock);
        cpu_chip_enable = 1'b1; cpu_operation = c_ram_read; cpu_addr = 32'h0000_0300;
        mem_ack = 1'b0;
        @(negedge clock);
        @(negedge clock);
        #1;
        check("pre_rst_mem_request", mem_request, 1);
        reset = 1'b1;
        #1;
        check("rst_async_mem_request", mem_request, 0);
        cpu_chip_enable = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        base_rises = req_rises;
        @(negedge clock);
        mem_ack = 1'b1; mem_read_data = 32'hFFFF_FFFF;
        @(negedge clock);
        mem_ack = 1'b0;
        #1;
        check("late_ack_mem_request", mem_request, 0);
        check("late_ack_rdata", cpu_read_data, 0);
        check("late_ack_bus_error", bus_error, 0);
        @(negedge clock);
        check("late_ack_no_request", req_rises - base_rises, 0);
        run_vec(tbl[0], 10);
        cpu_chip_enable = 1'b0;

`ifdef RAM_BUS_BRIDGE_WRITE_POST_EN
        // Posted write at 0x10 immediately followed by a read at 0x14
        @(negedge clock);
        cpu_chip_enable = 1'b1; cpu_operation = c_ram_write; cpu_select_signal = 4'hF;
        cpu_addr = 32'h0000_0010; cpu_write_data = 32'hCAFE_F00D;
        #1;
        check("post_wr_no_stall", stall_request, 0);
        @(negedge clock);
        cpu_operation = c_ram_read; cpu_addr = 32'h0000_0014;
        p_e.rd = 32'h1122_3344; p_e.err = 0; p_e.stall = 8;
        sb_q.push_back(p_e);
        p_seen = 0; p_stalls = 0; p_cyc = 0; p_done = 1'b0;
        while (!p_done) begin
            #1;
            if (mem_request) begin
                mem_ack       = (p_seen == 2);
                mem_read_data = mem_write_enable ? 32'h0 : 32'h1122_3344;
                p_seen        = (p_seen == 2) ? 0 : p_seen + 1;
            end else begin
                mem_ack = 1'b0;
            end
            if (!stall_request) begin
                p_done = 1'b1;
                p_e = sb_q.pop_front();
                check("post_rd_rdata", cpu_read_data, p_e.rd);
                check("post_rd_stall_cycles", p_stalls, p_e.stall);
                check("post_rd_mem_addr", mem_addr, 32'h0000_0014);
            end else begin
                p_stalls++;
            end
            p_cyc++;
            if (!p_done && p_cyc > 40) begin
                check("post_release_timeout", 0, 1);
                p_done = 1'b1;
            end
            @(negedge clock);
        end
        mem_ack = 1'b0;
        cpu_chip_enable = 1'b0;
`endif

        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
